// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - register-file read with writeback bypass and a one-entry ALU issue register
module operand_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [63:0] imm,
  input  logic        use_imm,
  input  logic [1:0]  op_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [63:0] wb_data,
  output logic [63:0] ALU_Input1,
  output logic [63:0] ALU_Input2,
  output logic [1:0]  Signal,
  output logic [4:0]  out_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] issue_count
);

  logic [63:0] rf_q [32];

  logic [63:0] alu1_q, alu1_d;
  logic [63:0] alu2_q, alu2_d;
  logic [1:0]  sig_q, sig_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic        wb_live;
  logic        accept;
  logic [63:0] opnd1, opnd2;

  assign wb_live = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_live) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // x0 is hard-wired to zero; a same-cycle writeback wins over the stored value.
  always_comb begin
    opnd1 = '0;
    opnd2 = '0;
    if (rs1_addr != 5'd0) opnd1 = (wb_live && wb_addr == rs1_addr) ? wb_data : rf_q[rs1_addr];
    if (rs2_addr != 5'd0) opnd2 = (wb_live && wb_addr == rs2_addr) ? wb_data : rf_q[rs2_addr];
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu1_d  = alu1_q;
    alu2_d  = alu2_q;
    sig_d   = sig_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    count_d = count_q;
    if (accept) begin
      alu1_d  = opnd1;
      alu2_d  = use_imm ? imm : opnd2;
      sig_d   = op_in;
      rd_d    = rd_addr;
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu1_q  <= '0;
      alu2_q  <= '0;
      sig_q   <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      alu1_q  <= alu1_d;
      alu2_q  <= alu2_d;
      sig_q   <= sig_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign ALU_Input1  = alu1_q;
  assign ALU_Input2  = alu2_q;
  assign Signal      = sig_q;
  assign out_rd      = rd_q;
  assign out_valid   = valid_q;
  assign issue_count = count_q;

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have `in_valid`, input, 1 bit: an upstream instruction is presented this cycle.
REQ-004 SHALL have `in_ready`, output, 1 bit: this block accepts the presented instruction this cycle.
REQ-005 SHALL have `rs1_addr`, input, 5 bits: source register 1 index.
REQ-006 SHALL have `rs2_addr`, input, 5 bits: source register 2 index.
REQ-007 SHALL have `rd_addr`, input, 5 bits: destination index, passed through unchanged.
REQ-008 SHALL have `imm`, input, 64 bits: immediate operand.
REQ-009 SHALL have `use_imm`, input, 1 bit: when 1, operand 2 is `imm` instead of rs2.
REQ-010 SHALL have `op_in`, input, 2 bits: ALU operation code, passed through.
REQ-011 SHALL have `wb_en`, input, 1 bit: register write enable from writeback.
REQ-012 SHALL have `wb_addr`, input, 5 bits: writeback register index.
REQ-013 SHALL have `wb_data`, input, 64 bits: writeback data.
REQ-014 SHALL have `ALU_Input1`, output, 64 bits: registered operand 1 to the ALU.
REQ-015 SHALL have `ALU_Input2`, output, 64 bits: registered operand 2 to the ALU.
REQ-016 SHALL have `Signal`, output, 2 bits: registered op code to the ALU.
REQ-017 SHALL have `out_rd`, output, 5 bits: registered destination index.
REQ-018 SHALL have `out_valid`, output, 1 bit: output register holds a valid instruction.
REQ-019 SHALL have `out_ready`, input, 1 bit: downstream consumes the output this cycle.
REQ-020 SHALL have `issue_count`, output, 16 bits: count of accepted instructions.

Function
REQ-021 SHALL contain a 32 x 64-bit register file; x0 reads 0 always; writes with `wb_addr`=0 are ignored.
REQ-022 SHALL write `wb_data` to entry `wb_addr` at the clock edge when `wb_en`=1 and `wb_addr`!=0.
REQ-023 SHALL bypass reads: if `wb_en`=1, `wb_addr`!=0 and `wb_addr` equals a source index, that operand takes `wb_data` in the same cycle.
REQ-024 SHALL drive `in_ready` = !`out_valid` | `out_ready` (combinational).
REQ-025 SHALL accept on `in_valid` & `in_ready` and load, at the next edge: operand 1 into `ALU_Input1`; (`use_imm` ? `imm` : operand 2) into `ALU_Input2`; `op_in` into `Signal`; `rd_addr` into `out_rd`; and set `out_valid`=1. Latency 1 cycle.
REQ-026 SHALL clear `out_valid` at the edge when `out_valid`=1, `out_ready`=1 and no accept occurs.
REQ-027 SHALL hold all output-register fields stable while `out_valid`=1 and `out_ready`=0, including across later register-file writes.
REQ-028 SHALL handle simultaneous consume and accept by loading the new instruction with `out_valid` staying 1 (no bubble).
REQ-029 SHALL not change output-register fields when `in_valid`=0 or `in_ready`=0.
REQ-030 SHALL increment `issue_count` by 1 per accept, wrapping 0xFFFF -> 0x0000.
REQ-031 SHALL pass through and ignore the value of `op_in`; there are no illegal codes.

Reset
REQ-032 SHALL, while `rst`=1 and independent of `clk`, force every register-file entry, `ALU_Input1`, `ALU_Input2`, `Signal`, `out_rd` and `issue_count` to 0, and `out_valid` to 0.
REQ-033 SHALL discard any held output instruction on reset mid-operation; `in_ready`=1 in the first cycle after `rst` deasserts.

Verification
REQ-034 SHALL pass: write x5=0x10, x6=0x20; issue rs1=5, rs2=6, use_imm=0, op=01, rd=7 -> next cycle `ALU_Input1`=0x10, `ALU_Input2`=0x20, `Signal`=01, `out_rd`=7, `out_valid`=1.
REQ-035 SHALL pass: issue with wb_en=1, wb_addr=5, wb_data=0xABCD and rs1=5 in the same cycle -> `ALU_Input1`=0xABCD.
REQ-036 SHALL pass: write x0=0xFF, then issue rs1=0, use_imm=1, imm=0x1234 -> `ALU_Input1`=0, `ALU_Input2`=0x1234.
REQ-037 SHALL pass: hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0 and outputs unchanged; then `out_ready`=1 -> new instruction loaded next cycle with no bubble.
REQ-038 SHALL pass: 65536 accepts -> `issue_count` wraps to 0.
REQ-039 SHALL pass: assert `rst` while `out_valid`=1 -> `out_valid`=0 and all registers 0 immediately.
